ex9_top: RTL and testbench



---
 rtl/ex9_top.sv | 79 +++++++
 tb/tb_ex9_top.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ex9_top.sv
// Start/stop decimal counter: a debounced-by-edge push switch toggles STOP/RUN,
// and in RUN the 0..MAXV count advances once per prescaler tick.
module ex9_top #(
    parameter int unsigned DIV  = 1,
    parameter int unsigned MAXV = 9
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SW1,
    output logic [3:0] OUT
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAXV);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sync1_q, sync2_q, dly_q;
    logic               press_c;
    logic               tick_c;

    // Two-flop synchronizer plus delay stage; a press is the synchronized rising edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= SW1;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign press_c = sync2_q & ~dly_q;
    assign tick_c  = (pre_q == PRE_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_STOP;
            pre_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counting keys off the pre-edge state, so the stopping edge still counts.
    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        cnt_d   = cnt_q;

        if (press_c) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end

        if (state_q == ST_RUN && tick_c) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        if (state_q == ST_RUN && state_d == ST_RUN && !tick_c) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    assign OUT = cnt_q;

endmodule

// File: tb/tb_ex9_top.sv
// Bench for ex9_top: directed timeline plus random switch/reset traffic,
// checked against an edge-scheduled behavioural model for two parameter sets.
module tb_ex9_top;

    localparam int DIV_A  = 1;
    localparam int MAXV_A = 9;
    localparam int DIV_B  = 3;
    localparam int MAXV_B = 5;

    logic       CLK;
    logic       RST;
    logic       SW1;
    logic [3:0] out_a;
    logic [3:0] out_b;

    int n_checks;
    int n_errors;

    ex9_top #(.DIV(DIV_A), .MAXV(MAXV_A)) u_dut_a (
        .CLK (CLK),
        .RST (RST),
        .SW1 (SW1),
        .OUT (out_a)
    );

    ex9_top #(.DIV(DIV_B), .MAXV(MAXV_B)) u_dut_b (
        .CLK (CLK),
        .RST (RST),
        .SW1 (SW1),
        .OUT (out_b)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: a sampled rising edge of SW1 schedules a toggle two edges later;
    // in RUN the count advances on every DIV-th edge since entering RUN.
    int  edge_n;
    bit  prev_samp;
    int  toggle_q[$];
    bit  m_run[2];
    int  m_cnt[2];
    int  m_rcyc[2];

    initial begin
        edge_n    = 0;
        prev_samp = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_run[i]  = 1'b0;
            m_cnt[i]  = 0;
            m_rcyc[i] = 0;
        end
    end

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_samp = 1'b0;
            toggle_q.delete();
            for (int i = 0; i < 2; i++) begin
                m_run[i]  = 1'b0;
                m_cnt[i]  = 0;
                m_rcyc[i] = 0;
            end
        end else begin
            bit tog;
            edge_n++;
            tog = 1'b0;
            if (toggle_q.size() > 0 && toggle_q[0] == edge_n) begin
                tog = 1'b1;
                void'(toggle_q.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                int dv;
                int mx;
                dv = (i == 0) ? DIV_A : DIV_B;
                mx = (i == 0) ? MAXV_A : MAXV_B;
                if (m_run[i] && (m_rcyc[i] % dv == dv - 1))
                    m_cnt[i] = (m_cnt[i] + 1) % (mx + 1);
                if (m_run[i])
                    m_rcyc[i]++;
                if (tog) begin
                    m_run[i]  = !m_run[i];
                    m_rcyc[i] = 0;
                end
            end
            if (SW1 && !prev_samp)
                toggle_q.push_back(edge_n + 2);
            prev_samp = SW1;
        end
    end

    // Every falling edge: both DUTs against the model, and the range limit.
    always @(negedge CLK) begin
        check_eq("model_a", int'(out_a), m_cnt[0]);
        check_eq("model_b", int'(out_b), m_cnt[1]);
        check_eq("range_a", int'(out_a <= 4'(MAXV_A)), 1);
        check_eq("range_b", int'(out_b <= 4'(MAXV_B)), 1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST = 1'b1;
        SW1 = 1'b0;

        #100 check_eq("rst_out", int'(out_a), 0);
        #100 RST = 1'b0;                                   // 200
        #100 check_eq("idle", int'(out_a), 0); SW1 = 1'b1; // 300
        #100 SW1 = 1'b0;                                   // 400
        #100 check_eq("pre_run", int'(out_a), 0);          // 500
        #100 check_eq("run_start", int'(out_a), 0); SW1 = 1'b1; // 600
        #100 check_eq("cnt1", int'(out_a), 1); SW1 = 1'b0;      // 700
        #100 check_eq("cnt2", int'(out_a), 2);             // 800
        #100 check_eq("stop_last", int'(out_a), 3);        // 900
        #800 check_eq("held", int'(out_a), 3); SW1 = 1'b1; // 1700
        #100 SW1 = 1'b0;                                   // 1800
        #100 check_eq("held2", int'(out_a), 3);            // 1900
        #100 check_eq("resume_edge", int'(out_a), 3);      // 2000
        #100 check_eq("resume4", int'(out_a), 4);          // 2100
        #400 check_eq("cnt8", int'(out_a), 8);             // 2500
        #100 check_eq("cnt9", int'(out_a), 9);             // 2600
        #100 check_eq("wrap0", int'(out_a), 0);            // 2700
        #100 check_eq("wrap1", int'(out_a), 1);            // 2800

        // Long hold: one toggle only (stops at 3050 with OUT=4).
        SW1 = 1'b1;
        repeat (20) @(negedge CLK);
        check_eq("hold_once", int'(out_a), 4);             // 4800
        SW1 = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("hold_stop", int'(out_a), 4);             // 5000

        // Back to RUN, reach 7, then reset with a press in flight.
        SW1 = 1'b1;
        @(negedge CLK); SW1 = 1'b0;                        // 5100
        repeat (5) @(negedge CLK);                         // 5600
        check_eq("pre_rst7", int'(out_a), 7);
        SW1 = 1'b1;
        #10 RST = 1'b1;
        #1 check_eq("async_rst_a", int'(out_a), 0);
        check_eq("async_rst_b", int'(out_b), 0);
        @(negedge CLK);                                    // 5700
        RST = 1'b0;
        SW1 = 1'b0;
        repeat (5) @(negedge CLK);
        check_eq("rst_no_run", int'(out_a), 0);

        // Random switch traffic with occasional async resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 9) < 2)
                SW1 = ~SW1;
            if ($urandom_range(0, 149) == 0) begin
                #10 RST = 1'b1;
                #1 check_eq("rnd_rst_a", int'(out_a), 0);
                check_eq("rnd_rst_b", int'(out_b), 0);
                #20 RST = 1'b0;
            end
        end
        SW1 = 1'b0;
        repeat (4) @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
